// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line typedefs, pmem offset width and the
// pmem responder FSM state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int PMEM_OFFSET_W = 4;

    typedef enum logic [1:0] {
        PMEM_IDLE,
        PMEM_BUSY,
        PMEM_RESP,
        PMEM_RECOVER
    } pmem_state_e;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port synchronous line array with registered read data.
// Ports: clk, rst (resets rdata only), re/we strobes, idx, wdata, rdata.
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int LINE_IDX_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic                  we,
    input  logic [LINE_IDX_W-1:0] idx,
    input  lc3b_line              wdata,
    output lc3b_line              rdata
);

    lc3b_line mem [2**LINE_IDX_W];
    lc3b_line rdata_q;
    lc3b_line rdata_d;

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read data holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Line-granular physical memory responder with fixed request latency.
// Ports: clk, rst, pmem_read/write/address/wdata in; pmem_resp/rdata/error out.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int LINE_IDX_W = 6,
    parameter int LATENCY    = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     pmem_read,
    input  logic     pmem_write,
    input  lc3b_word pmem_address,
    input  lc3b_line pmem_wdata,
    output logic     pmem_resp,
    output lc3b_line pmem_rdata,
    output logic     pmem_error
);

    pmem_state_e           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [LINE_IDX_W-1:0] idx_q, idx_d;
    lc3b_line              wdata_q, wdata_d;
    logic                  resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  arr_re;
    logic                  arr_we;
    logic                  addr_unused;

    // Offset and alias bits above the index are don't-cares.
    assign addr_unused = ^pmem_address;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        arr_re  = 1'b0;
        arr_we  = 1'b0;
        unique case (state_q)
            PMEM_IDLE: begin
                if (pmem_read || pmem_write) begin
                    // A read+write collision resolves as a write.
                    op_wr_d = pmem_write;
                    idx_d   = pmem_address[PMEM_OFFSET_W +: LINE_IDX_W];
                    wdata_d = pmem_wdata;
                    cnt_d   = 8'(LATENCY - 1);
                    err_d   = pmem_read && pmem_write;
                    state_d = PMEM_BUSY;
                end
            end
            PMEM_BUSY: begin
                if (cnt_q == 8'd0) begin
                    // Read lands in rdata on the same edge RESP begins.
                    arr_re  = !op_wr_q;
                    resp_d  = 1'b1;
                    state_d = PMEM_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PMEM_RESP: begin
                arr_we  = op_wr_q;
                state_d = PMEM_RECOVER;
            end
            PMEM_RECOVER: begin
                state_d = PMEM_IDLE;
            end
            default: begin
                state_d = PMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PMEM_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    pmem_line_array #(
        .LINE_IDX_W(LINE_IDX_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .re   (arr_re),
        .we   (arr_we),
        .idx  (idx_q),
        .wdata(wdata_q),
        .rdata(pmem_rdata)
    );

    assign pmem_resp  = resp_q;
    assign pmem_error = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: LATENCY=4 and LATENCY=1 instances.
module tb_pmem_responder;
    import lc3b_types::*;

    localparam lc3b_line L3 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam lc3b_line DB = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam lc3b_line CF = 128'hCAFE_F00D_0123_4567_89AB_CDEF_CAFE_F00D;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    lc3b_word ad0 = '0, ad1 = '0;
    lc3b_line wd0 = '0, wd1 = '0;
    logic     resp0, resp1, err0, err1;
    lc3b_line rdata0, rdata1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pmem_responder #(.LINE_IDX_W(6), .LATENCY(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .pmem_read(rd0), .pmem_write(wr0),
        .pmem_address(ad0), .pmem_wdata(wd0),
        .pmem_resp(resp0), .pmem_rdata(rdata0), .pmem_error(err0)
    );

    pmem_responder #(.LINE_IDX_W(6), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(ad1), .pmem_wdata(wd1),
        .pmem_resp(resp1), .pmem_rdata(rdata1), .pmem_error(err1)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input lc3b_word a, input lc3b_line d);
        if (sel) begin
            rd1 = r; wr1 = w; ad1 = a; wd1 = d;
        end else begin
            rd0 = r; wr0 = w; ad0 = a; wd0 = d;
        end
    endtask

    // Drive from IDLE, wait for resp, deassert, return in IDLE again.
    // lat/errk are counted in cycles from the acceptance edge.
    task automatic run_req(input bit sel, input logic r, input logic w,
                           input lc3b_word a, input lc3b_line d,
                           output lc3b_line q, output int lat,
                           output int errn, output int errk);
        q = '0; lat = -1; errn = 0; errk = -1;
        drive(sel, r, w, a, d);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sel ? err1 : err0) begin
                errn++;
                if (errk < 0) errk = k - 1;
            end
            if (sel ? resp1 : resp0) begin
                lat = k - 1;
                q = sel ? rdata1 : rdata0;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("resp_1cyc", {127'b0, sel ? resp1 : resp0}, 128'd0);
        @(negedge clk);
    endtask

    lc3b_line q;
    int lat, errn, errk, n, t1, t2, t3;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_resp0", {127'b0, resp0}, 128'd0);
        chk("rst_err0", {127'b0, err0}, 128'd0);
        chk("rst_rdata0", rdata0, 128'd0);
        chk("rst_rdata1", rdata1, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Preload line 3, then read it back.
        run_req(0, 0, 1, 16'h0030, L3, q, lat, errn, errk);
        chk("wr3_lat", lat, 4);
        run_req(0, 1, 0, 16'h0030, '0, q, lat, errn, errk);
        chk("rd3_lat", lat, 4);
        chk("rd3_data", q, L3);
        chk("rd3_err", errn, 0);

        // Offset bits ignored; writes leave rdata alone.
        run_req(0, 0, 1, 16'h0052, DB, q, lat, errn, errk);
        chk("wr5_rdata_hold", rdata0, L3);
        run_req(0, 1, 0, 16'h005E, '0, q, lat, errn, errk);
        chk("rd5_data", q, DB);
        chk("rd5_hold", rdata0, DB);

        // Collision is a write plus an error pulse.
        run_req(0, 1, 1, 16'h0010, 128'h1, q, lat, errn, errk);
        chk("col_errn", errn, 1);
        chk("col_errk", errk, 0);
        chk("col_lat", lat, 4);
        run_req(0, 1, 0, 16'h0010, '0, q, lat, errn, errk);
        chk("rd1_data", q, 128'h1);

        // Reset in the middle of a write aborts it.
        run_req(0, 0, 1, 16'h0070, 128'hA5, q, lat, errn, errk);
        drive(0, 0, 1, 16'h0070, 128'hFF);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_resp", {127'b0, resp0}, 128'd0);
        chk("arst_err", {127'b0, err0}, 128'd0);
        chk("arst_rdata", rdata0, 128'd0);
        drive(0, 0, 0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_req(0, 1, 0, 16'h0070, '0, q, lat, errn, errk);
        chk("rd7_after_rst", q, 128'hA5);

        // Read held 3 cycles past resp: RECOVER ignores it, IDLE takes it once.
        drive(0, 1, 0, 16'h0070, '0);
        n = 0; t1 = -1; t2 = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (resp0) begin
                n++;
                if (n == 1) t1 = k;
                else if (n == 2) t2 = k;
            end
            if (k == 8) drive(0, 0, 0, '0, '0);
        end
        chk("hold_n", n, 2);
        chk("hold_t1", t1, 5);
        chk("hold_t2", t2, 12);
        chk("hold_data", rdata0, 128'hA5);

        // LATENCY=1 instance: aliasing and back-to-back reads.
        run_req(1, 0, 1, 16'h0000, CF, q, lat, errn, errk);
        chk("l1_wr_lat", lat, 1);
        run_req(1, 1, 0, 16'h0400, '0, q, lat, errn, errk);
        chk("l1_alias_data", q, CF);
        chk("l1_rd_lat", lat, 1);

        drive(1, 1, 0, 16'h0400, '0);
        n = 0; t1 = -1; t2 = -1; t3 = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (resp1) begin
                if (n == 0) t1 = k;
                else if (n == 1) t2 = k;
                else if (n == 2) t3 = k;
                n++;
                drive(1, 0, 0, '0, '0);
            end else if (!rd1 && n < 3) begin
                drive(1, 1, 0, 16'h0400, '0);
            end
        end
        chk("b2b_n", n, 3);
        chk("b2b_t1", t1, 2);
        chk("b2b_gap1", t2 - t1, 4);
        chk("b2b_gap2", t3 - t2, 4);
        chk("b2b_data", rdata1, CF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
